lsu_align: RTL
==============

# lsu_align

Load/store alignment unit sitting directly upstream of the data memory in the MEM stage. Accepts one load or store request at a time and converts the byte address and `funct3` into word-aligned memory addresses, per-lane write strobes and lane-shifted write data. It also extracts and sign- or zero-extends load data from the returned word(s). Misaligned accesses either fault or are split into two word accesses, selected at compile time.

## Interface
- `DM_ADDRESS`, default 9: byte-address width of the data memory.
- `DATA_W`, default 32: data width; only 32 is supported.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V `funct3`; loads 000/001/010/100/101, stores 000/001/010.
- `req_addr`  in  DM_ADDRESS  byte address from the ALU.
- `req_wdata`  in  DATA_W  store data, right-justified.
- `rsp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `rsp_rdata`  out  DATA_W  extended load data; 0 for stores and faults.
- `rsp_fault`  out  1  access rejected; qualified by `rsp_valid`.
- `mem_raddress`  out  32  word-aligned byte address, zero-extended.
- `mem_waddress`  out  32  same value as `mem_raddress`.
- `mem_datain`  out  DATA_W  lane-positioned write data.
- `mem_wr`  out  4  byte-lane write strobes; bit i = byte lane i.
- `mem_dataout`  in  DATA_W  memory read word.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE: a handshake occurs on `req_valid && req_ready`. On handshake, latch all `req_*` signals and go to ACC0, or go to RESP if the request faults.
  - ACC0: perform the first word access, then go to ACC1 if the access is split, else RESP.
  - ACC1: perform the second word access, then go to RESP.
  - RESP: assert `rsp_valid`, then go to IDLE.
- Definitions: o = `addr[1:0]`; w0 = `addr[DM_ADDRESS-1:2]`; w1 = w0+1 modulo 2^(DM_ADDRESS-2), so the top word wraps to word 0.
- Size masks: byte = 4'b0001, half = 4'b0011, word = 4'b1111. Let m8 = {4'b0, mask} << o.
- Write data: d64 = {32'b0, wdata} << (8*o).
  - ACC0 drives `mem_wr` = m8[3:0] and `mem_datain` = d64[31:0].
  - ACC1 drives `mem_wr` = m8[7:4] and `mem_datain` = d64[63:32].
- Loads drive `mem_wr` = 0.
  - ACC0 captures `mem_dataout` into lo; ACC1 captures it into hi (hi = 0 if no ACC1).
  - Result r = {hi, lo} >> (8*o).
  - LB sign-extends r[7:0]; LBU zero-extends r[7:0]; LH sign-extends r[15:0]; LHU zero-extends r[15:0]; LW passes r[31:0].
- A request is misaligned when it is a half with o==3 or a word with o!=0.
- A request faults when either holds:
  - illegal `funct3` (load 011/110/111; store anything other than 000/001/010);
  - misaligned while the macro is off.
- A faulting request issues no memory access: `mem_wr` stays 0, `rsp_fault` = 1, `rsp_rdata` = 0.
- Outside ACC0/ACC1: `mem_wr` = 0, `mem_datain` = 0, addresses = 0.

## Timing
- The memory returns `mem_dataout` within the same cycle the address is driven (it is clocked on the falling edge). The unit samples it at the rising edge ending ACC0/ACC1.
- Latency from the handshake edge to `rsp_valid`:
  - aligned access: 2 cycles;
  - split access: 3 cycles;
  - fault: 1 cycle.
- Peak throughput: one request per 3 cycles.
- `rsp_valid`, `rsp_rdata` and `rsp_fault` are registered and held only during RESP. There is no backpressure on the response.
- `req_ready` is low in every non-IDLE state.
- Reset takes priority over all events, including a handshake in the same cycle.
  - Reset forces IDLE and clears lo/hi.
  - Output values while `reset` is high: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_fault` = 0, `mem_wr` = 0, `mem_datain` = 0, addresses = 0.
  - Reset asserted between ACC0 and ACC1 abandons the second half. The ACC0 write has already occurred and is not undone.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined:
  - misaligned halves and words are split into ACC0 + ACC1;
  - `rsp_fault` is asserted only for illegal `funct3`.
- Undefined:
  - ACC1 is unreachable and may be optimized away;
  - every misaligned access faults, with no memory traffic.

## Test plan
- **LW aligned:** LW at 0x010, `mem_dataout` = 0xDEADBEEF. Required: `mem_raddress` = 0x10, `mem_wr` = 0. `rsp_valid` pulses 2 cycles after the handshake with `rsp_rdata` = 0xDEADBEEF and `rsp_fault` = 0.
- **SB at offset 3:** SB at 0x013, `wdata` = 0x000000A5. Required: ACC0 `mem_waddress` = 0x10, `mem_wr` = 4'b1000, `mem_datain` = 0xA5000000.
- **Sign/zero extension:** memory word 0x00008180.
  - LB at 0x020 returns 0xFFFFFF80.
  - LBU at 0x021 returns 0x00000081.
  - LH at 0x020 returns 0xFFFF8180.
- **Misaligned LH:** LH at 0x013, words 0x11223344 at 0x10 and 0x55667788 at 0x14.
  - With the macro: 2 accesses; `rsp_rdata` = 0xFFFF8811 and `rsp_fault` = 0 after 3 cycles.
  - Without the macro: `rsp_fault` = 1, `rsp_rdata` = 0, `mem_wr` never nonzero, response after 1 cycle.
- **Wrap-around (macro on):** SW at 0x1FE, `wdata` = 0xCAFEBABE. Required:
  - ACC0: `mem_waddress` = 0x1FC, `mem_wr` = 4'b1100, `mem_datain` = 0xBABE0000.
  - ACC1: `mem_waddress` = 0x000, `mem_wr` = 4'b0011, `mem_datain` = 0x0000CAFE.
- **Reset mid-split (macro on):** assert `reset` during ACC1. Required: next cycle IDLE, `mem_wr` = 0, no `rsp_valid`; `req_ready` = 1 the cycle after `reset` drops.

Source files
------------

// File: rtl/lsu_align_if.sv
// rtl/lsu_align_if.sv - request, response and data-memory signals of the load/store alignment unit
interface lsu_align_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_fault;
  logic [31:0]           mem_raddress;
  logic [31:0]           mem_waddress;
  logic [DATA_W-1:0]     mem_datain;
  logic [3:0]            mem_wr;
  logic [DATA_W-1:0]     mem_dataout;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dataout,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_raddress, mem_waddress, mem_datain, mem_wr
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dataout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_raddress, mem_waddress, mem_datain, mem_wr
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit; LSU_MISALIGN_SPLIT_EN splits misaligned accesses
// into two word accesses instead of faulting them.
module lsu_align #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  lsu_align_if.slave  bus
);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t                state, state_next;
  logic                  write_q;
  logic [2:0]            f3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [31:0]           lo, rdata_q;
  logic                  fault_q;

  logic                  ready, hs, split;
  logic [1:0]            o;
  logic [DM_ADDRESS-3:0] w0, w1, word;
  logic [3:0]            mask, wr;
  logic [7:0]            m8;
  logic [63:0]           d64, cap64, r64;
  logic [31:0]           r, ext, datain;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off == 2'b11) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic faults(input logic wr_op, input logic [2:0] f3, input logic [1:0] off);
    logic illegal;
    illegal = wr_op ? (f3 != 3'b000 && f3 != 3'b001 && f3 != 3'b010)
                    : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    return illegal || (!SPLIT_EN && misaligned(f3, off));
  endfunction

  assign o     = addr_q[1:0];
  assign w0    = addr_q[DM_ADDRESS-1:2];
  assign w1    = w0 + (DM_ADDRESS-2)'(1);
  assign split = SPLIT_EN && misaligned(f3_q, o);
  assign hs    = (state == IDLE) && bus.req_valid && !reset;

  always_comb begin
    case (f3_q[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  assign m8  = {4'b0000, mask} << o;
  assign d64 = {32'b0, wdata_q} << {o, 3'b000};

  // In ACC1 the low word comes from the ACC0 capture, the high word straight off the bus.
  assign cap64 = (state == ACC1) ? {bus.mem_dataout, lo} : {32'b0, bus.mem_dataout};
  assign r64   = cap64 >> {o, 3'b000};
  assign r     = r64[31:0];

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{r[7]}}, r[7:0]};
      3'b100:  ext = {24'b0, r[7:0]};
      3'b001:  ext = {{16{r[15]}}, r[15:0]};
      3'b101:  ext = {16'b0, r[15:0]};
      default: ext = r;
    endcase
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    wr         = 4'b0000;
    datain     = 32'b0;
    word       = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid)
          state_next = faults(bus.req_write, bus.req_funct3, bus.req_addr[1:0]) ? RESP : ACC0;
      end
      ACC0: begin
        word       = w0;
        wr         = write_q ? m8[3:0] : 4'b0000;
        datain     = d64[31:0];
        state_next = split ? ACC1 : RESP;
      end
      ACC1: begin
        word       = w1;
        wr         = write_q ? m8[7:4] : 4'b0000;
        datain     = d64[63:32];
        state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      state_next = IDLE;
      ready      = 1'b0;
      wr         = 4'b0000;
      datain     = 32'b0;
      word       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      write_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      lo      <= 32'b0;
      rdata_q <= 32'b0;
      fault_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (hs) begin
          write_q <= bus.req_write;
          f3_q    <= bus.req_funct3;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          fault_q <= faults(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
          rdata_q <= 32'b0;
        end
        ACC0: begin
          lo <= bus.mem_dataout;
          if (!split) rdata_q <= write_q ? 32'b0 : ext;
        end
        ACC1: rdata_q <= write_q ? 32'b0 : ext;
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = ready;
  assign bus.rsp_valid    = (state == RESP) && !reset;
  assign bus.rsp_rdata    = bus.rsp_valid ? rdata_q : 32'b0;
  assign bus.rsp_fault    = bus.rsp_valid && fault_q;
  assign bus.mem_raddress = 32'({word, 2'b00});
  assign bus.mem_waddress = 32'({word, 2'b00});
  assign bus.mem_wr       = wr;
  assign bus.mem_datain   = datain;
endmodule
